// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: operand forwarding selects, data/mult-div stall
// generation, a multiply/divide busy tracker and a saturating stall counter.
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs_D,
    input  logic [AW-1:0] rt_D,
    input  logic [1:0]    tuse_rs_D,
    input  logic [1:0]    tuse_rt_D,
    input  logic [AW-1:0] wa_E,
    input  logic [AW-1:0] wa_M,
    input  logic [AW-1:0] wa_W,
    input  logic [1:0]    tnew_E,
    input  logic [1:0]    tnew_M,
    input  logic [AW-1:0] rs_E,
    input  logic [AW-1:0] rt_E,
    input  logic [AW-1:0] rt_M,
    input  logic          md_start_E,
    input  logic          md_div_E,
    input  logic          md_use_D,
    input  logic          flush,
    output logic          stall,
    output logic          clr_E,
    output logic [1:0]    fwd_rs_D,
    output logic [1:0]    fwd_rt_D,
    output logic [1:0]    fwd_rs_E,
    output logic [1:0]    fwd_rt_E,
    output logic          fwd_rt_M,
    output logic          md_busy,
    output logic [CW-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_t;

    // The busy counter holds latency-1 so that a latency of 1 yields one BUSY cycle.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_LAT - 1);

    generate
        if ((NREG != (1 << AW)) || (MUL_LAT < 1) || (MUL_LAT > 15) ||
            (DIV_LAT < 1) || (DIV_LAT > 15)) begin : g_bad_cfg
            $error("hazard_scoreboard: illegal parameter set");
        end
    endgenerate

    md_state_t      r_state;
    md_state_t      w_state_nxt;
    logic [3:0]     r_cnt;
    logic [3:0]     w_cnt_nxt;
    logic [CW-1:0]  r_stall_cnt;
    logic           w_data_stall;
    logic           w_md_stall;
    logic           w_stall;

    function automatic logic f_match(input logic [AW-1:0] src, input logic [AW-1:0] wa);
        return (src == wa) && (wa != {AW{1'b0}});
    endfunction

    function automatic logic f_src_stall(input logic [AW-1:0] src, input logic [1:0] tuse,
                                         input logic [AW-1:0] wae, input logic [1:0] tne,
                                         input logic [AW-1:0] wam, input logic [1:0] tnm);
        return (f_match(src, wae) && (tuse < tne)) || (f_match(src, wam) && (tuse < tnm));
    endfunction

    // Youngest producer wins; an unready youngest producer falls back to the register file.
    function automatic logic [1:0] f_fwd_d(input logic [AW-1:0] src,
                                           input logic [AW-1:0] wae, input logic [1:0] tne,
                                           input logic [AW-1:0] wam, input logic [1:0] tnm,
                                           input logic [AW-1:0] waw);
        logic [1:0] sel;
        if (f_match(src, wae)) begin
            sel = (tne == 2'd0) ? 2'b01 : 2'b00;
        end else if (f_match(src, wam)) begin
            sel = (tnm == 2'd0) ? 2'b10 : 2'b00;
        end else if (f_match(src, waw)) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    function automatic logic [1:0] f_fwd_e(input logic [AW-1:0] src,
                                           input logic [AW-1:0] wam, input logic [1:0] tnm,
                                           input logic [AW-1:0] waw);
        logic [1:0] sel;
        if (f_match(src, wam) && (tnm == 2'd0)) begin
            sel = 2'b10;
        end else if (f_match(src, waw)) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Combinational forwarding selects and stall terms.
    always_comb begin
        w_data_stall = f_src_stall(rs_D, tuse_rs_D, wa_E, tnew_E, wa_M, tnew_M) ||
                       f_src_stall(rt_D, tuse_rt_D, wa_E, tnew_E, wa_M, tnew_M);
        w_md_stall   = reset && md_use_D && ((r_state == S_BUSY) || md_start_E);
        w_stall      = w_data_stall || w_md_stall;
        fwd_rs_D     = f_fwd_d(rs_D, wa_E, tnew_E, wa_M, tnew_M, wa_W);
        fwd_rt_D     = f_fwd_d(rt_D, wa_E, tnew_E, wa_M, tnew_M, wa_W);
        fwd_rs_E     = f_fwd_e(rs_E, wa_M, tnew_M, wa_W);
        fwd_rt_E     = f_fwd_e(rt_E, wa_M, tnew_M, wa_W);
        fwd_rt_M     = f_match(rt_M, wa_W);
    end

    // Multiply/divide next-state logic; flush outranks a new start.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
        end else if (md_start_E) begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = md_div_E ? DIV_LOAD : MUL_LOAD;
        end else begin
            case (r_state)
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                S_IDLE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // Multiply/divide state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= {CW{1'b0}};
        end else if (w_stall && (r_stall_cnt != {CW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall     = w_stall;
    assign clr_E     = w_stall;
    assign md_busy   = (r_state == S_BUSY);
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers; index 0 is hard-wired zero.
REQ-002 Parameter AW, default 5: register address width, equal to log2(NREG).
REQ-003 Parameter MUL_LAT, default 5: mult/multu busy cycles, range 1..15.
REQ-004 Parameter DIV_LAT, default 10: div/divu busy cycles, range 1..15.
REQ-005 Parameter CW, default 16: width of the stall event counter.
REQ-006 clk  in  1: single clock; all state updates on the rising edge.
REQ-007 reset  in  1: asynchronous, active-low reset.
REQ-008 rs_D, rt_D  in  AW each: D-stage source register addresses.
REQ-009 tuse_rs_D, tuse_rt_D  in  2 each: cycles until the D-stage instruction needs the operand; 3 means unused.
REQ-010 wa_E, wa_M, wa_W  in  AW each: destination address per stage; 0 means no write.
REQ-011 tnew_E, tnew_M  in  2 each: cycles until that stage's result is produced; W results are always ready.
REQ-012 rs_E, rt_E  in  AW each: E-stage source addresses.
REQ-013 rt_M  in  AW: M-stage store-data source address.
REQ-014 md_start_E  in  1: a mult/div is in E this cycle.
REQ-015 md_div_E  in  1: 1 = div, 0 = mult; valid with md_start_E.
REQ-016 md_use_D  in  1: the D-stage instruction reads or writes HI/LO, or is a new mult/div.
REQ-017 flush  in  1: pipeline flush; cancels the multiply/divide busy state.
REQ-018 stall  out  1: freeze PC and the F/D register.
REQ-019 clr_E  out  1: insert a bubble into the D/E register; always equals stall.
REQ-020 fwd_rs_D, fwd_rt_D  out  2 each: 00 = register file, 01 = E, 10 = M, 11 = W.
REQ-021 fwd_rs_E, fwd_rt_E  out  2 each: 00 = pipe, 10 = M, 11 = W.
REQ-022 fwd_rt_M  out  1: 1 = take W result.
REQ-023 md_busy  out  1: the multiply/divide unit is occupied.
REQ-024 stall_cnt  out  CW: count of stall cycles.

Function
REQ-025 A match against stage X occurs when the source address equals wa_X and wa_X is not 0.
REQ-026 Data stall is asserted when rs_D matches E and tuse_rs_D < tnew_E, or rs_D matches M and tuse_rs_D < tnew_M; the same rule applies to rt_D.
REQ-027 Forward selection for D takes the youngest match in priority order E, then M, then W.
REQ-028 For D, E is selectable only when tnew_E = 0 and M only when tnew_M = 0; if the youngest match is not ready, fwd_*_D = 00 and the stall from REQ-026 covers it.
REQ-029 Forward selection for E: M when the source matches M and tnew_M = 0, otherwise W when it matches W, otherwise 00.
REQ-030 fwd_rt_M = 1 when rt_M matches wa_W.
REQ-031 Multiply/divide FSM has two states, IDLE and BUSY, plus a 4-bit down-counter cnt.
REQ-032 IDLE to BUSY on md_start_E: cnt loads DIV_LAT-1 if md_div_E, otherwise MUL_LAT-1.
REQ-033 In BUSY, cnt decrements each cycle; BUSY returns to IDLE on the edge where cnt = 0.
REQ-034 A latency of 1 gives exactly one BUSY cycle.
REQ-035 md_busy = (state == BUSY).
REQ-036 A multiply/divide stall is asserted when md_use_D and (md_busy or md_start_E).
REQ-037 stall = data stall OR multiply/divide stall.
REQ-038 flush forces the FSM to IDLE and cnt to 0 on the next edge and has priority over md_start_E.
REQ-039 flush does not mask the combinational stall in the same cycle.
REQ-040 A md_start_E while BUSY is illegal, because REQ-036 prevents it; if it occurs, the counter reloads.
REQ-041 stall_cnt increments on every edge where stall = 1 and saturates at 2^CW-1; flush does not clear it.
REQ-042 All forwarding and stall outputs are combinational from the current inputs and state; the block adds no added latency.

Reset
REQ-043 While reset = 0: state = IDLE, cnt = 0, stall_cnt = 0, md_busy = 0, independent of clk.
REQ-044 During reset, stall follows only the data-stall term.
REQ-045 Reset asserted mid-BUSY aborts the operation immediately.
REQ-046 On release, the first active edge behaves as from IDLE.

Verification
REQ-047 Load-use: wa_E = 8, tnew_E = 2, rs_D = 8, tuse_rs_D = 1 -> stall = 1, clr_E = 1; next cycle with wa_M = 8, tnew_M = 1, tuse 0 -> stall = 1; then wa_W = 8 -> stall = 0, fwd_rs_D = 11.
REQ-048 ALU chain: wa_M = 3, tnew_M = 0, rs_E = 3, and wa_W = 3 -> fwd_rs_E = 10 (M wins over W); with wa_M = 0 -> fwd_rs_E = 11.
REQ-049 Zero register: wa_E = 0, rs_D = 0, tnew_E = 2 -> stall = 0, fwd_rs_D = 00.
REQ-050 Divide: md_start_E = 1, md_div_E = 1, DIV_LAT = 10, md_use_D = 1 held -> stall high for 11 cycles (start cycle plus 10 BUSY), md_busy high for 10, then stall = 0; stall_cnt = 11.
REQ-051 Flush mid-multiply: MUL_LAT = 5, flush on the 2nd BUSY cycle -> md_busy = 0 on the next edge; stall_cnt is not cleared.
REQ-052 Saturation and reset: with CW = 4, stall held for 20 cycles -> stall_cnt = 15; reset pulled low asynchronously mid-BUSY -> md_busy = 0 and stall_cnt = 0 before the next clk edge.
